lvds_phy_rx_align: RTL

- Receive-side counterpart of the LVDS PHY transmitter, in the clk_link domain.
- Consumes the 2-bit-per-clk_link samples captured by the DDIO input cell and rebuilds the serial bit stream.
- Locates the 10-bit symbol boundary using the K28.5 comma and emits aligned 10-bit symbols, with a valid strobe, to the RX CDC FIFO write port.

---
 rtl/ltpi_phy_pkg.sv | 21 ++
 rtl/lvds_rx_comma_detect.sv | 16 +
 rtl/lvds_phy_rx_align.sv | 138 +++++++++++++
 3 files changed

// File: rtl/ltpi_phy_pkg.sv
// Shared LVDS PHY definitions: K28.5 comma encodings, alignment FSM states
// and per-mode phase terminal counts.
package ltpi_phy_pkg;

    localparam logic [9:0] K28_5_RDN = 10'h17C;
    localparam logic [9:0] K28_5_RDP = 10'h283;

    localparam logic [3:0] PH_TC_DDR = 4'd4;
    localparam logic [3:0] PH_TC_SDR = 4'd9;

    typedef enum logic [1:0] {
        HUNT,
        VERIFY,
        LOCKED
    } align_state_t;

    function automatic logic is_comma(input logic [9:0] win);
        return (win == K28_5_RDN) || (win == K28_5_RDP);
    endfunction

endpackage

// File: rtl/lvds_rx_comma_detect.sv
// Combinational K28.5 match on the two candidate symbol windows.
module lvds_rx_comma_detect
    import ltpi_phy_pkg::*;
(
    input  logic [9:0] win0,
    input  logic [9:0] win1,
    output logic       hit0,
    output logic       hit1
);

    always_comb begin
        hit0 = is_comma(win0);
        hit1 = is_comma(win1);
    end

endmodule

// File: rtl/lvds_phy_rx_align.sv
// LVDS RX symbol aligner: rebuilds the serial stream from DDIO samples and
// locks to K28.5. Build option LVDS_RX_ALIGN_STATS_EN enables realign_cnt.
module lvds_phy_rx_align
    import ltpi_phy_pkg::*;
#(
    parameter int unsigned LOCK_COMMAS     = 4,
    parameter int unsigned UNLOCK_MISALIGN = 3
) (
    input  logic       clk_link,
    input  logic       reset,
    input  logic       LVDS_DDR,
    input  logic [1:0] rx_ddr,
    output logic [9:0] sym_out,
    output logic       sym_valid,
    output logic       aligned,
    output logic       comma_det,
    output logic [7:0] realign_cnt
);

    localparam logic [3:0] LOCK_N   = 4'(LOCK_COMMAS);
    localparam logic [3:0] UNLOCK_N = 4'(UNLOCK_MISALIGN);

    align_state_t state;
    logic [11:0]  shreg;
    logic [3:0]   ph;
    logic [3:0]   good_cnt;
    logic [3:0]   bad_cnt;
    logic         sel;

    logic [9:0]   win0, win1, sel_win;
    logic         hit0, hit1_raw, hit1;
    logic [3:0]   ph_tc;
    logic         boundary, any_hit, good_hit, stray_hit;
    logic         hunt_lock, leaving;

    assign win0 = shreg[11:2];
    assign win1 = shreg[10:1];

    lvds_rx_comma_detect u_comma (
        .win0 (win0),
        .win1 (win1),
        .hit0 (hit0),
        .hit1 (hit1_raw)
    );

    always_comb begin
        hit1      = hit1_raw & LVDS_DDR;
        ph_tc     = LVDS_DDR ? PH_TC_DDR : PH_TC_SDR;
        boundary  = (ph == ph_tc);
        sel_win   = sel ? win1 : win0;
        any_hit   = hit0 | hit1;
        good_hit  = boundary & (sel ? hit1 : hit0);
        stray_hit = any_hit & ~good_hit;
        hunt_lock = (LOCK_N == 4'd1);
        // Lock is dropped on the misaligned comma that completes the bad run.
        leaving   = (state == LOCKED) & stray_hit & (bad_cnt + 4'd1 == UNLOCK_N);
    end

    always_ff @(posedge clk_link or posedge reset) begin
        if (reset) begin
            state     <= HUNT;
            shreg     <= '0;
            ph        <= '0;
            good_cnt  <= '0;
            bad_cnt   <= '0;
            sel       <= 1'b0;
            sym_out   <= '0;
            sym_valid <= 1'b0;
            aligned   <= 1'b0;
            comma_det <= 1'b0;
        end else begin
            shreg     <= LVDS_DDR ? {rx_ddr[0], rx_ddr[1], shreg[11:2]}
                                  : {rx_ddr[1], shreg[11:1]};
            comma_det <= any_hit;
            sym_valid <= 1'b0;
            ph        <= (ph >= ph_tc) ? '0 : ph + 4'd1;

            case (state)
                HUNT, VERIFY: begin
                    if (state == VERIFY && good_hit) begin
                        good_cnt <= good_cnt + 4'd1;
                        if (good_cnt + 4'd1 >= LOCK_N) begin
                            state   <= LOCKED;
                            aligned <= 1'b1;
                            bad_cnt <= '0;
                        end
                    end else if (any_hit) begin
                        // A stray comma in VERIFY restarts the search from this hit.
                        sel      <= ~hit0;
                        ph       <= '0;
                        good_cnt <= 4'd1;
                        bad_cnt  <= '0;
                        if (hunt_lock) begin
                            state   <= LOCKED;
                            aligned <= 1'b1;
                        end else begin
                            state <= VERIFY;
                        end
                    end
                end
                LOCKED: begin
                    if (good_hit) begin
                        bad_cnt <= '0;
                    end else if (stray_hit) begin
                        if (leaving) begin
                            state   <= HUNT;
                            aligned <= 1'b0;
                            bad_cnt <= '0;
                        end else begin
                            bad_cnt <= bad_cnt + 4'd1;
                        end
                    end
                    if (boundary && !leaving) begin
                        sym_out   <= sel_win;
                        sym_valid <= 1'b1;
                    end
                end
                default: begin
                    state   <= HUNT;
                    aligned <= 1'b0;
                end
            endcase
        end
    end

`ifdef LVDS_RX_ALIGN_STATS_EN
    always_ff @(posedge clk_link or posedge reset) begin
        if (reset) begin
            realign_cnt <= '0;
        end else if (leaving && realign_cnt != 8'hFF) begin
            realign_cnt <= realign_cnt + 8'd1;
        end
    end
`else
    assign realign_cnt = 8'h00;
`endif

endmodule
